// File: rtl/id_exe_reg.sv
// id_exe_reg: decode -> execute pipeline register for the ARM-subset core.
// Priority per edge: flush (bubble) > freeze (hold) > hazard (bubble) > load.
// A loaded instruction whose condition failed keeps its data but loses all
// side-effect controls and its valid bit.
// Optional macro ID_EXE_PERF_CNT_EN adds bubble/squash/stall counters.
module id_exe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              hazard,
   input  logic              valid_in,
   input  logic              cond_ok_in,
   input  logic              WB_EN_in,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic              B_in,
   input  logic              S_in,
   input  logic [3:0]        EXE_CMD_in,
   input  logic [DATA_W-1:0] PC_in,
   input  logic [DATA_W-1:0] Val_Rn_in,
   input  logic [DATA_W-1:0] Val_Rm_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [11:0]       Shift_operand_in,
   input  logic [23:0]       Signed_imm_24_in,
   input  logic [REG_W-1:0]  Dest_in,
   input  logic [REG_W-1:0]  src1_in,
   input  logic [REG_W-1:0]  src2_in,
   input  logic              Two_src_in,
   input  logic [3:0]        SR_in,
   output logic              WB_EN_out,
   output logic              MEM_R_EN_out,
   output logic              MEM_W_EN_out,
   output logic              B_out,
   output logic              S_out,
   output logic [3:0]        EXE_CMD_out,
   output logic [DATA_W-1:0] PC_out,
   output logic [DATA_W-1:0] Val_Rn_out,
   output logic [DATA_W-1:0] Val_Rm_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [11:0]       Shift_operand_out,
   output logic [23:0]       Signed_imm_24_out,
   output logic [REG_W-1:0]  Dest_out,
   output logic [REG_W-1:0]  src1_out,
   output logic [REG_W-1:0]  src2_out,
   output logic              Two_src_out,
   output logic [3:0]        SR_out,
`ifdef ID_EXE_PERF_CNT_EN
   output logic [31:0]       bubble_cnt,
   output logic [31:0]       squash_cnt,
   output logic [31:0]       stall_cnt,
`endif
   output logic              valid_out
);

   // flush wins over freeze so a killed branch shadow never survives a stall
   logic bubble, hold, live;
   assign bubble = flush || (!freeze && hazard);
   assign hold   = !flush && freeze;
   assign live   = valid_in && cond_ok_in;

   // pipeline register: data always follows inputs unless held; controls gated
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_out         <= 1'b0;
         WB_EN_out         <= 1'b0;
         MEM_R_EN_out      <= 1'b0;
         MEM_W_EN_out      <= 1'b0;
         B_out             <= 1'b0;
         S_out             <= 1'b0;
         Two_src_out       <= 1'b0;
         EXE_CMD_out       <= '0;
         PC_out            <= '0;
         Val_Rn_out        <= '0;
         Val_Rm_out        <= '0;
         imm_out           <= '0;
         Shift_operand_out <= '0;
         Signed_imm_24_out <= '0;
         Dest_out          <= '0;
         src1_out          <= '0;
         src2_out          <= '0;
         SR_out            <= '0;
      end else if (!hold) begin
         // data fields, tags and flags load on both bubble and load
         PC_out            <= PC_in;
         Val_Rn_out        <= Val_Rn_in;
         Val_Rm_out        <= Val_Rm_in;
         imm_out           <= imm_in;
         Shift_operand_out <= Shift_operand_in;
         Signed_imm_24_out <= Signed_imm_24_in;
         Dest_out          <= Dest_in;
         src1_out          <= src1_in;
         src2_out          <= src2_in;
         SR_out            <= SR_in;
         if (bubble) begin
            valid_out    <= 1'b0;
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            B_out        <= 1'b0;
            S_out        <= 1'b0;
            Two_src_out  <= 1'b0;
            EXE_CMD_out  <= 4'b0000;
         end else begin
            valid_out    <= live;
            WB_EN_out    <= WB_EN_in    && live;
            MEM_R_EN_out <= MEM_R_EN_in && live;
            MEM_W_EN_out <= MEM_W_EN_in && live;
            B_out        <= B_in        && live;
            S_out        <= S_in        && live;
            Two_src_out  <= Two_src_in  && live;
            EXE_CMD_out  <= EXE_CMD_in;
         end
      end
   end

`ifdef ID_EXE_PERF_CNT_EN
   // event counters, free-running and wrapping at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt <= '0;
         squash_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
         if (hold)   stall_cnt  <= stall_cnt + 32'd1;
         if (!bubble && !hold && valid_in && !cond_ok_in)
            squash_cnt <= squash_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: scoreboard bench for id_exe_reg. A reference model computes
// the expected register contents before each edge and queues them; each test
// task pops and compares after the edge. Counter checks under ID_EXE_PERF_CNT_EN.
module tb_id_exe_reg;

   typedef struct packed {
      logic        wb, mr, mw, b, s;
      logic [3:0]  cmd;
      logic [31:0] pc, rn, rm, imm;
      logic [11:0] shop;
      logic [23:0] simm;
      logic [3:0]  dest, s1, s2;
      logic        two;
      logic [3:0]  sr;
   } fields_t;

   typedef struct packed {
      logic    valid;
      fields_t f;
   } out_t;

   logic clk, rst, flush, freeze, hazard, valid_in, cond_ok_in;
   fields_t din;

   logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, Two_src_out, valid_out;
   logic [3:0]  EXE_CMD_out, Dest_out, src1_out, src2_out, SR_out;
   logic [31:0] PC_out, Val_Rn_out, Val_Rm_out, imm_out;
   logic [11:0] Shift_operand_out;
   logic [23:0] Signed_imm_24_out;
`ifdef ID_EXE_PERF_CNT_EN
   logic [31:0] bubble_cnt, squash_cnt, stall_cnt;
`endif

   id_exe_reg #(.DATA_W(32), .REG_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard(hazard),
      .valid_in(valid_in), .cond_ok_in(cond_ok_in),
      .WB_EN_in(din.wb), .MEM_R_EN_in(din.mr), .MEM_W_EN_in(din.mw),
      .B_in(din.b), .S_in(din.s), .EXE_CMD_in(din.cmd),
      .PC_in(din.pc), .Val_Rn_in(din.rn), .Val_Rm_in(din.rm), .imm_in(din.imm),
      .Shift_operand_in(din.shop), .Signed_imm_24_in(din.simm),
      .Dest_in(din.dest), .src1_in(din.s1), .src2_in(din.s2),
      .Two_src_in(din.two), .SR_in(din.sr),
      .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
      .B_out(B_out), .S_out(S_out), .EXE_CMD_out(EXE_CMD_out),
      .PC_out(PC_out), .Val_Rn_out(Val_Rn_out), .Val_Rm_out(Val_Rm_out), .imm_out(imm_out),
      .Shift_operand_out(Shift_operand_out), .Signed_imm_24_out(Signed_imm_24_out),
      .Dest_out(Dest_out), .src1_out(src1_out), .src2_out(src2_out),
      .Two_src_out(Two_src_out), .SR_out(SR_out),
`ifdef ID_EXE_PERF_CNT_EN
      .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt), .stall_cnt(stall_cnt),
`endif
      .valid_out(valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   out_t m;
   out_t q[$];
   logic [31:0] m_bub, m_sq, m_st;

   function automatic out_t obs();
      out_t o;
      o.valid = valid_out;
      o.f.wb = WB_EN_out; o.f.mr = MEM_R_EN_out; o.f.mw = MEM_W_EN_out;
      o.f.b = B_out; o.f.s = S_out; o.f.cmd = EXE_CMD_out;
      o.f.pc = PC_out; o.f.rn = Val_Rn_out; o.f.rm = Val_Rm_out; o.f.imm = imm_out;
      o.f.shop = Shift_operand_out; o.f.simm = Signed_imm_24_out;
      o.f.dest = Dest_out; o.f.s1 = src1_out; o.f.s2 = src2_out;
      o.f.two = Two_src_out; o.f.sr = SR_out;
      return o;
   endfunction

   function automatic out_t bubble_of(fields_t d);
      out_t o;
      o.valid = 1'b0;
      o.f = d;
      o.f.wb = 1'b0; o.f.mr = 1'b0; o.f.mw = 1'b0; o.f.b = 1'b0; o.f.s = 1'b0;
      o.f.two = 1'b0; o.f.cmd = 4'b0000;
      return o;
   endfunction

   // model next register state from the current inputs, queue it, take the edge
   task automatic cycle();
      logic lv;
      lv = valid_in & cond_ok_in;
      if (!rst) begin
         m = '0; m_bub = 0; m_sq = 0; m_st = 0;
      end else if (flush) begin
         m = bubble_of(din); m_bub = m_bub + 1;
      end else if (freeze) begin
         m_st = m_st + 1;
      end else if (hazard) begin
         m = bubble_of(din); m_bub = m_bub + 1;
      end else begin
         m.f = din;
         m.valid = lv;
         m.f.wb = din.wb & lv; m.f.mr = din.mr & lv; m.f.mw = din.mw & lv;
         m.f.b = din.b & lv; m.f.s = din.s & lv; m.f.two = din.two & lv;
         if (valid_in && !cond_ok_in) m_sq = m_sq + 1;
      end
      q.push_back(m);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      din = '0; flush = 0; freeze = 0; hazard = 0; valid_in = 0; cond_ok_in = 0;
   endtask

   task automatic test_reset();
      out_t e, g;
      rst = 1'b1;
      din = '1; flush = 1; freeze = 1; hazard = 1; valid_in = 1; cond_ok_in = 1;
      #1 rst = 1'b0;
      m = '0; m_bub = 0; m_sq = 0; m_st = 0;
      #1;
      g = obs(); n_vec++;
      if (g !== out_t'('0)) begin n_err++; $display("FAIL reset_async got=%h exp=0", g); end
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || g.valid !== 1'b0) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", g, e); end
`ifdef ID_EXE_PERF_CNT_EN
      n_vec++;
      if (bubble_cnt !== 0 || squash_cnt !== 0 || stall_cnt !== 0) begin
         n_err++; $display("FAIL reset_cnt got=%h/%h/%h exp=0", bubble_cnt, squash_cnt, stall_cnt);
      end
`endif
      #2 rst = 1'b1;
      idle_inputs();
      din.dest = 4'h5; din.wb = 1; valid_in = 1; cond_ok_in = 1;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || Dest_out !== 4'h5 || WB_EN_out !== 1'b1 || valid_out !== 1'b1) begin
         n_err++; $display("FAIL first_load got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_freeze();
      out_t e, g;
      idle_inputs();
      valid_in = 1; cond_ok_in = 1; din.rn = 32'hDEADBEEF; din.wb = 1;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL freeze_load got=%h exp=%h", g, e); end
      freeze = 1; din.rn = 32'h12345678; din.dest = 4'h9;
      for (int i = 0; i < 3; i++) begin
         cycle();
         e = q.pop_front(); g = obs(); n_vec++;
         if (g !== e || Val_Rn_out !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL freeze_hold%0d got=%h exp=%h", i, g, e);
         end
      end
      freeze = 0;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || Val_Rn_out !== 32'h12345678) begin
         n_err++; $display("FAIL freeze_release got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_hazard();
      out_t e, g;
      idle_inputs();
      valid_in = 1; cond_ok_in = 1; din.mw = 1; din.cmd = 4'h2; din.rm = 32'hA5A5_0F0F;
      hazard = 1;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || MEM_W_EN_out !== 1'b0 || EXE_CMD_out !== 4'h0 || valid_out !== 1'b0
          || Val_Rm_out !== 32'hA5A5_0F0F) begin
         n_err++; $display("FAIL hazard_bubble got=%h exp=%h", g, e);
      end
      hazard = 0;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || MEM_W_EN_out !== 1'b1 || EXE_CMD_out !== 4'h2 || valid_out !== 1'b1) begin
         n_err++; $display("FAIL hazard_reload got=%h exp=%h", g, e);
      end
      // hazard during a stall holds; the bubble comes after the stall
      hazard = 1; freeze = 1; din.cmd = 4'h7;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || EXE_CMD_out !== 4'h2 || valid_out !== 1'b1) begin
         n_err++; $display("FAIL hazard_freeze got=%h exp=%h", g, e);
      end
      freeze = 0;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || valid_out !== 1'b0 || EXE_CMD_out !== 4'h0) begin
         n_err++; $display("FAIL hazard_after_stall got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_flush_freeze();
      out_t e, g;
      logic [31:0] b0, s0;
      idle_inputs();
      valid_in = 1; cond_ok_in = 1; din.b = 1; din.simm = 24'h800001;
      cycle();
      void'(q.pop_front());
      b0 = m_bub; s0 = m_st;
`ifdef ID_EXE_PERF_CNT_EN
      b0 = bubble_cnt; s0 = stall_cnt;
`endif
      flush = 1; freeze = 1;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || B_out !== 1'b0 || valid_out !== 1'b0) begin
         n_err++; $display("FAIL flush_over_freeze got=%h exp=%h", g, e);
      end
`ifdef ID_EXE_PERF_CNT_EN
      n_vec++;
      if (bubble_cnt !== b0 + 32'd1 || stall_cnt !== s0 || bubble_cnt !== m_bub) begin
         n_err++; $display("FAIL flush_cnt got=%0d/%0d exp=%0d/%0d", bubble_cnt, stall_cnt, b0 + 1, s0);
      end
`endif
   endtask

   task automatic test_cond_fail();
      out_t e, g;
      logic [31:0] sq0;
      idle_inputs();
      sq0 = m_sq;
`ifdef ID_EXE_PERF_CNT_EN
      sq0 = squash_cnt;
`endif
      valid_in = 1; cond_ok_in = 0; din.wb = 1; din.dest = 4'hA; din.mr = 1;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || WB_EN_out !== 1'b0 || valid_out !== 1'b0 || Dest_out !== 4'hA
          || MEM_R_EN_out !== 1'b0) begin
         n_err++; $display("FAIL cond_fail got=%h exp=%h", g, e);
      end
`ifdef ID_EXE_PERF_CNT_EN
      n_vec++;
      if (squash_cnt !== sq0 + 32'd1) begin
         n_err++; $display("FAIL squash_cnt got=%0d exp=%0d", squash_cnt, sq0 + 1);
      end
`endif
   endtask

   task automatic test_async_reset_stall();
      out_t e, g;
      idle_inputs();
      valid_in = 1; cond_ok_in = 1; din.wb = 1; din.dest = 4'h3; din.pc = 32'h100;
      cycle();
      void'(q.pop_front());
      freeze = 1;
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || valid_out !== 1'b1) begin n_err++; $display("FAIL stall_live got=%h exp=%h", g, e); end
      #2 rst = 1'b0;
      m = '0; m_bub = 0; m_sq = 0; m_st = 0;
      #1;
      g = obs(); n_vec++;
      if (g !== out_t'('0)) begin n_err++; $display("FAIL reset_mid_stall got=%h exp=0", g); end
      cycle();
      e = q.pop_front(); g = obs(); n_vec++;
      if (g !== e || valid_out !== 1'b0) begin n_err++; $display("FAIL reset_stall_edge got=%h exp=%h", g, e); end
      #2 rst = 1'b1;
      freeze = 0;
   endtask

   task automatic test_back_to_back();
      out_t e, g;
      logic [191:0] r;
      for (int i = 0; i < 300; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         din = r[189:0];
         if (din.mr) din.mw = 1'b0;
         valid_in = ($urandom_range(0, 3) != 0);
         cond_ok_in = ($urandom_range(0, 4) != 0);
         flush = ($urandom_range(0, 9) == 0);
         freeze = ($urandom_range(0, 4) == 0);
         hazard = ($urandom_range(0, 6) == 0);
         cycle();
         e = q.pop_front(); g = obs(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL rand%0d got=%h exp=%h", i, g, e); end
         n_vec++;
         if (MEM_R_EN_out === 1'b1 && MEM_W_EN_out === 1'b1) begin
            n_err++; $display("FAIL rand_memrw%0d got=11 exp=not both", i);
         end
      end
`ifdef ID_EXE_PERF_CNT_EN
      n_vec++;
      if (bubble_cnt !== m_bub || squash_cnt !== m_sq || stall_cnt !== m_st) begin
         n_err++; $display("FAIL rand_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                           bubble_cnt, squash_cnt, stall_cnt, m_bub, m_sq, m_st);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_freeze();
      test_hazard();
      test_flush_freeze();
      test_cond_fail();
      test_async_reset_stall();
      test_back_to_back();
      n_vec++;
      if (q.size() != 0) begin n_err++; $display("FAIL queue_drain got=%0d exp=0", q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
